i2c_master_nb: RTL and testbench

I2C_MASTER_NB -- requirements
Module: i2c_master_nb

---
 rtl/i2c_master_nb.sv | 190 +++++++++++++++++++
 tb/tb_i2c_master_nb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_nb.sv
`timescale 1ns/1ps
// I2C master that runs one write, read or address-probe transaction per start pulse.
// Define I2C_ADDR_RETRY_EN to retry an address NACK up to three more times before reporting it.
module i2c_master_nb #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] nbytes,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             scl,
    inout  wire              sda
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WBYTE, WACK, RBYTE, MACK, STOP
    } state_t;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t           state, state_n;
    logic [7:0]       div_cnt;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       addr_q;
    logic [LEN_W-1:0] count;
    logic             ack_q;
    logic             sda_low;
    logic             sda_in;
    logic             retry_pend;
    logic             addr_nack_final;
    logic             tick_q, bit_end, byte_end, sample_pt, first_clk, shifting;

    assign sda_in    = sda;
    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign tick_q    = (div_cnt == DIV_LAST);
    assign bit_end   = tick_q && (quarter == 2'd3);
    assign byte_end  = bit_end && (bit_cnt == 3'd7);
    assign sample_pt = tick_q && (quarter == 2'd1);
    assign first_clk = (div_cnt == 8'd0) && (quarter == 2'd0) && (bit_cnt == 3'd0);
    assign shifting  = (state == ADDR) || (state == WBYTE) || (state == RBYTE);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

`ifdef I2C_ADDR_RETRY_EN
    logic [1:0] retry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt  <= 2'd0;
            retry_pend <= 1'b0;
        end else if (state == IDLE && start) begin
            retry_cnt  <= 2'd0;
            retry_pend <= 1'b0;
        end else if (state == ADDR_ACK && bit_end && ack_q && retry_cnt != 2'd3) begin
            retry_cnt  <= retry_cnt + 2'd1;
            retry_pend <= 1'b1;
        end else if (state == STOP && bit_end) begin
            retry_pend <= 1'b0;
        end
    end

    assign addr_nack_final = (retry_cnt == 2'd3);
`else
    assign retry_pend      = 1'b0;
    assign addr_nack_final = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= 8'd0;
            quarter  <= 2'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            addr_q   <= 8'd0;
            count    <= '0;
            ack_q    <= 1'b0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= 8'd0;
                quarter <= 2'd0;
                bit_cnt <= 3'd0;
                if (start) begin
                    addr_q   <= {slave_addr, rw};
                    count    <= nbytes;
                    nack_err <= 1'b0;
                end
            end else begin
                div_cnt <= tick_q ? 8'd0 : div_cnt + 8'd1;
                if (tick_q)              quarter <= quarter + 2'd1;
                if (bit_end && shifting) bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                START:    shreg <= addr_q;
                ADDR:     if (bit_end) shreg <= {shreg[6:0], 1'b0};
                WBYTE: begin
                    if (first_clk)    shreg <= wr_data;
                    else if (bit_end) shreg <= {shreg[6:0], 1'b0};
                end
                RBYTE: if (sample_pt) begin
                    shreg <= {shreg[6:0], sda_in};
                    if (bit_cnt == 3'd7) begin
                        rd_data  <= {shreg[6:0], sda_in};
                        rd_valid <= 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (sample_pt) ack_q <= sda_in;
                    if (bit_end && ack_q && addr_nack_final) nack_err <= 1'b1;
                end
                WACK: begin
                    if (sample_pt) ack_q <= sda_in;
                    if (bit_end) begin
                        if (ack_q)            nack_err <= 1'b1;
                        else if (count != '0) count    <= count - ONE;
                    end
                end
                MACK:    if (bit_end && count != '0) count <= count - ONE;
                default: ;
            endcase
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = START;
            START:    if (bit_end) state_n = ADDR;
            ADDR:     if (byte_end) state_n = ADDR_ACK;
            ADDR_ACK: if (bit_end) begin
                if (ack_q || count == '0) state_n = STOP;
                else if (addr_q[0])       state_n = RBYTE;
                else                      state_n = WBYTE;
            end
            WBYTE:    if (byte_end) state_n = WACK;
            WACK:     if (bit_end) state_n = (ack_q || count <= ONE) ? STOP : WBYTE;
            RBYTE:    if (byte_end) state_n = MACK;
            MACK:     if (bit_end) state_n = (count > ONE) ? RBYTE : STOP;
            STOP:     if (bit_end) state_n = retry_pend ? START : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Data bits: SCL high in Q1/Q2; START and STOP move SDA at Q2 entry while SCL is high.
    always_comb begin
        scl     = quarter[1] ^ quarter[0];
        sda_low = 1'b0;
        case (state)
            IDLE:  scl = 1'b1;
            START: begin
                scl     = (quarter != 2'd3);
                sda_low = quarter[1];
            end
            ADDR:  sda_low = ~shreg[7];
            WBYTE: sda_low = first_clk ? ~wr_data[7] : ~shreg[7];
            MACK:  sda_low = (count > ONE);
            STOP: begin
                scl     = (quarter != 2'd0);
                sda_low = ~quarter[1];
            end
            default: ;
        endcase
        busy   = (state != IDLE);
        wr_req = (state == WBYTE) && first_clk && !rst;
        done   = (state == STOP) && bit_end && !retry_pend && !rst;
    end

endmodule

// File: tb/tb_i2c_master_nb.sv
`timescale 1ns/1ps
// Bench for i2c_master_nb: a bus-level slave model feeds scoreboards of bytes, read data and
// master ACK bits; table-driven transactions plus hand-written reset and busy-start sequences.
module tb_i2c_master_nb;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 4;
`ifdef I2C_ADDR_RETRY_EN
    localparam int NACK_TRIES = 4;
`else
    localparam int NACK_TRIES = 1;
`endif

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0]       slave_addr = 7'h00;
    logic [LEN_W-1:0] nbytes = '0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_req, rd_valid, busy, done, nack_err, scl;
    logic [7:0]       rd_data;
    wire              sda;
    logic             slv_low = 1'b0;

    pullup (sda);
    assign sda = (slv_low && !rst) ? 1'b0 : 1'bz;

    i2c_master_nb #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_addr(slave_addr),
        .nbytes(nbytes), .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .nack_err(nack_err),
        .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_wrreq = 0, n_rdv = 0, n_done = 0, n_start = 0, n_stop = 0;
    logic [7:0] exp_bus[$], exp_rd[$], tx_q[$], wq[$];
    logic       exp_mack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bus-level slave: acknowledges address 0x48, accepts writes, sends tx_q on reads.
    typedef enum {SL_IDLE, SL_ADDR, SL_WR, SL_RD} sl_t;
    localparam logic [6:0] MY_ADDR = 7'h48;
    sl_t        ph = SL_IDLE;
    int         bit_i = 0;
    logic [7:0] sh = 8'h00, tx = 8'hFF;
    logic       pscl = 1'b1, psda = 1'b1, mack_bit = 1'b1;

    always @(negedge clk) begin
        logic cs, cc;
        logic [7:0] e8;
        logic       e1;
        cs = sda;
        cc = scl;
        if (rst) begin
            ph = SL_IDLE; slv_low = 1'b0; bit_i = 0;
        end else if (pscl && cc && psda && !cs) begin
            n_start++; ph = SL_ADDR; bit_i = 0; sh = 8'h00; slv_low = 1'b0;
        end else if (pscl && cc && !psda && cs) begin
            n_stop++; ph = SL_IDLE; slv_low = 1'b0;
        end else if (!pscl && cc) begin
            if (bit_i < 8 && ph != SL_RD) sh = {sh[6:0], cs};
            if (bit_i == 8 && ph == SL_RD) begin
                mack_bit = cs;
                e1 = (exp_mack.size() != 0) ? exp_mack.pop_front() : 1'bx;
                check("mack", {31'd0, mack_bit}, {31'd0, e1});
            end
            bit_i++;
        end else if (pscl && !cc) begin
            if (bit_i == 8) begin
                if (ph == SL_ADDR || ph == SL_WR) begin
                    e8 = (exp_bus.size() != 0) ? exp_bus.pop_front() : 8'hxx;
                    check("bus_byte", {24'd0, sh}, {24'd0, e8});
                end
                slv_low = (ph == SL_ADDR) ? (sh[7:1] == MY_ADDR) : (ph == SL_WR);
            end else if (bit_i == 9) begin
                slv_low = 1'b0;
                bit_i   = 0;
                if (ph == SL_ADDR) ph = (sh[7:1] == MY_ADDR) ? (sh[0] ? SL_RD : SL_WR) : SL_IDLE;
                else if (ph == SL_RD && mack_bit) ph = SL_IDLE;
                if (ph == SL_RD) begin
                    tx = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
                    slv_low = !tx[7];
                end
            end else if (ph == SL_RD && bit_i > 0 && bit_i < 8) begin
                slv_low = !tx[7 - bit_i];
            end
        end
        pscl = cc;
        psda = cs;
    end

    always @(negedge clk) begin
        logic [7:0] e8;
        if (done) n_done++;
        if (rd_valid) begin
            n_rdv++;
            e8 = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hxx;
            check("rd_data", {24'd0, rd_data}, {24'd0, e8});
        end
    end

    // Next write byte is presented once the current one has been loaded.
    always @(negedge clk) begin
        if (wr_req) begin
            n_wrreq++;
            @(posedge clk);
            #1;
            if (wq.size() != 0) wr_data = wq.pop_front();
        end
    end

    typedef struct {
        logic [6:0]       addr;
        logic             rw;
        logic [LEN_W-1:0] nb;
        logic [7:0]       d0, d1;
        int               poke;
        logic             exp_nack;
        int               exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc, tries, nw, nr;
        logic acked;
        acked = (v.addr == MY_ADDR);
        tries = acked ? 1 : NACK_TRIES;
        nw    = (acked && !v.rw) ? int'(v.nb) : 0;
        nr    = (acked &&  v.rw) ? int'(v.nb) : 0;
        n_wrreq = 0; n_rdv = 0; n_done = 0; n_start = 0; n_stop = 0;
        for (int i = 0; i < tries; i++) exp_bus.push_back({v.addr, v.rw});
        if (nw > 0) exp_bus.push_back(v.d0);
        if (nw > 1) begin exp_bus.push_back(v.d1); wq.push_back(v.d1); end
        for (int i = 0; i < nr; i++) begin
            tx_q.push_back(i == 0 ? v.d0 : v.d1);
            exp_rd.push_back(i == 0 ? v.d0 : v.d1);
            exp_mack.push_back(i == nr - 1);
        end
        @(negedge clk);
        wr_data = v.d0; slave_addr = v.addr; rw = v.rw; nbytes = v.nb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_nack_clr"}, {31'd0, nack_err}, 32'd0);
        cyc = 1;
        while (!done && cyc < 600) begin
            if (v.poke != 0 && cyc == v.poke) begin
                start = 1'b1; slave_addr = 7'h21; rw = 1'b1; nbytes = 4'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, "_done_cyc"}, cyc, v.exp_cyc);
        check({tag, "_nack_err"}, {31'd0, nack_err}, {31'd0, v.exp_nack});
        @(posedge clk); #1;
        check({tag, "_done_once"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_n_start"}, n_start, tries);
        check({tag, "_n_stop"}, n_stop, tries);
        check({tag, "_n_wrreq"}, n_wrreq, nw);
        check({tag, "_n_rdv"}, n_rdv, nr);
        check({tag, "_bus_left"}, exp_bus.size(), 0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
        check({tag, "_mack_left"}, exp_mack.size(), 0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{7'h48, 1'b0, 4'd1, 8'hA5, 8'h00, 0,  1'b0, 20 * 8};
        vecs[1] = '{7'h48, 1'b1, 4'd2, 8'h3C, 8'h7E, 0,  1'b0, 29 * 8};
        vecs[2] = '{7'h21, 1'b0, 4'd1, 8'h11, 8'h00, 0,  1'b1, NACK_TRIES * 11 * 8};
        vecs[3] = '{7'h48, 1'b0, 4'd0, 8'h00, 8'h00, 0,  1'b0, 11 * 8};
        vecs[4] = '{7'h48, 1'b0, 4'd2, 8'h5A, 8'hC3, 0,  1'b0, 29 * 8};
        vecs[5] = '{7'h48, 1'b0, 4'd1, 8'hA5, 8'h00, 40, 1'b0, 20 * 8};

        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda", {31'd0, sda}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_req", {31'd0, wr_req}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_nack_err", {31'd0, nack_err}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during bit 3 of the first read byte (bit period 13 of the transaction).
        n_done = 0; n_rdv = 0;
        exp_bus.push_back({7'h48, 1'b1});
        tx_q.push_back(8'h3C); tx_q.push_back(8'h7E);
        @(negedge clk);
        slave_addr = 7'h48; rw = 1'b1; nbytes = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 13 * 8 + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_scl", {31'd0, scl}, 32'd1);
        check("abort_sda", {31'd0, sda}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_n_done", n_done, 0);
        check("abort_n_rdv", n_rdv, 0);
        check("abort_bus_left", exp_bus.size(), 0);
        check("abort_scl_idle", {31'd0, scl}, 32'd1);
        tx_q.delete(); exp_rd.delete(); exp_mack.delete();

        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
